apb_bus_arbiter: RTL and testbench

- Two-requester APB master for the MCU peripheral bus. Requesters are the RISC-V core data port (m0) and a secondary master such as a debug or DMA port (m1).
- Arbitrates between the requesters round-robin, decodes the address to one of NUM_SLV slave selects (GPO, GPI, GPIO, UART, ...), and sequences the APB SETUP/ACCESS phases.
- Returns read data, a completion pulse and an error flag to the granted requester.

---
 rtl/mcu_apb_pkg.sv | 25 ++
 rtl/apb_rr_arb2.sv | 33 +++
 rtl/apb_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_apb_pkg.sv
// mcu_apb_pkg: shared state type, slave map and base address
// for the MCU APB master.
package mcu_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } apb_state_e;

  localparam int SLV_GPO  = 0;
  localparam int SLV_GPI  = 1;
  localparam int SLV_GPIO = 2;
  localparam int SLV_UART = 3;

  localparam logic [15:0] BASE_HI_DEF = 16'h1000;

  function automatic logic [3:0] slv_idx(
    input logic [31:0] a
  );
    return a[15:12];
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// apb_rr_arb2: two-way round-robin arbiter with one-hot grant.
// Pointer resets to "m1 granted last" so m0 wins the first tie.
module apb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_en && (|i_req)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: two-requester round-robin APB master with decode.
// Define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYC.
module apb_bus_arbiter
  import mcu_apb_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          NUM_SLV     = 4,
  parameter logic [15:0] BASE_HI     = BASE_HI_DEF,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic [ADDR_W-1:0]         m0_addr,
  input  logic [DATA_W-1:0]         m0_wdata,
  output logic [DATA_W-1:0]         m0_rdata,
  output logic                      m0_ready,
  output logic                      m0_err,
  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic [ADDR_W-1:0]         m1_addr,
  input  logic [DATA_W-1:0]         m1_wdata,
  output logic [DATA_W-1:0]         m1_rdata,
  output logic                      m1_ready,
  output logic                      m1_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic                      penable,
  output logic [DATA_W-1:0]         pwdata,
  output logic [NUM_SLV-1:0]        psel,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  apb_state_e        r_state;
  logic              r_own;
  logic [1:0]        w_elig;
  logic [1:0]        w_gnt;
  logic              w_we;
  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [3:0]        w_idx;
  logic [DATA_W-1:0] w_prd;
  logic              w_rdy;
  logic              w_serr;
  logic              w_tmo;
  logic              w_done;
  logic              w_done_err;
  logic [DATA_W-1:0] w_done_rd;

  // A requester whose ready pulse is showing has just finished.
  assign w_elig = {m1_req & ~m1_ready, m0_req & ~m0_ready};

  apb_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (reset),
    .i_req (w_elig),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt)
  );

  assign w_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign w_we    = w_gnt[1] ? m1_we    : m0_we;
  assign w_wdata = w_gnt[1] ? m1_wdata : m0_wdata;
  assign w_idx   = slv_idx(w_addr[31:0]);
  assign w_valid = (w_addr[31:16] == BASE_HI)
                && (32'(w_idx) < NUM_SLV);

  // Selected slave response, steered by the registered one-hot psel.
  always_comb begin
    w_prd  = '0;
    w_rdy  = 1'b0;
    w_serr = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel[i]) begin
        w_prd  = prdata[i*DATA_W +: DATA_W];
        w_rdy  = pready[i];
        w_serr = pslverr[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  assign w_tmo = (r_state == ACCESS) && !w_rdy
              && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_cnt <= '0;
    end else if ((r_state == ACCESS) && !w_rdy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic [31:0] w_unused_tmo;

  assign w_tmo        = 1'b0;
  assign w_unused_tmo = TIMEOUT_CYC;
`endif

  always_comb begin
    w_done     = 1'b0;
    w_done_err = 1'b0;
    w_done_rd  = '0;
    unique case (1'b1)
      (r_state == ACCESS) && w_rdy: begin
        w_done     = 1'b1;
        w_done_err = w_serr;
        w_done_rd  = pwrite ? '0 : w_prd;
      end
      w_tmo || (r_state == DERR): begin
        w_done     = 1'b1;
        w_done_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_own    <= 1'b0;
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      psel     <= '0;
      penable  <= 1'b0;
      m0_ready <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ready <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      m0_ready <= 1'b0;
      m0_err   <= 1'b0;
      m1_ready <= 1'b0;
      m1_err   <= 1'b0;
      if (w_done) begin
        psel    <= '0;
        penable <= 1'b0;
        r_state <= IDLE;
        if (r_own) begin
          m1_ready <= 1'b1;
          m1_err   <= w_done_err;
          m1_rdata <= w_done_rd;
        end else begin
          m0_ready <= 1'b1;
          m0_err   <= w_done_err;
          m0_rdata <= w_done_rd;
        end
      end else begin
        unique case (r_state)
          IDLE: begin
            if (|w_gnt) begin
              r_own  <= w_gnt[1];
              paddr  <= w_addr;
              pwrite <= w_we;
              pwdata <= w_wdata;
              if (w_valid) begin
                psel    <= NUM_SLV'(1) << w_idx;
                r_state <= SETUP;
              end else begin
                r_state <= DERR;
              end
            end
          end
          SETUP: begin
            penable <= 1'b1;
            r_state <= ACCESS;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb_apb_bus_arbiter: directed and randomized bench for apb_bus_arbiter
// against a transaction-level model of the bus, compared every cycle.
module tb_apb_bus_arbiter;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         m0_req, m0_we, m1_req, m1_we;
  logic [31:0]  m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0]  m0_rdata, m1_rdata;
  logic         m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0]  paddr, pwdata;
  logic         pwrite, penable;
  logic [3:0]   psel;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;

  int n_chk = 0;
  int n_err = 0;

  apb_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .m1_ready(m1_ready), .m1_err(m1_err),
    .paddr(paddr), .pwrite(pwrite), .penable(penable),
    .pwdata(pwdata), .psel(psel),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- requesters ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   order_q[$];
  int   n_done0 = 0;
  logic last_err0 = 1'b0;

  initial begin
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        m0_req = 0;
        m1_req = 0;
        q0.delete();
        q1.delete();
      end else begin
        if (m0_ready) begin
          m0_req = 0;
          n_done0++;
          last_err0 = m0_err;
          order_q.push_back(0);
          if (q0.size() > 0) void'(q0.pop_front());
        end else if (!m0_req && q0.size() > 0) begin
          m0_req = 1; m0_we = q0[0].we;
          m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
        end
        if (m1_ready) begin
          m1_req = 0;
          order_q.push_back(1);
          if (q1.size() > 0) void'(q1.pop_front());
        end else if (!m1_req && q1.size() > 0) begin
          m1_req = 1; m1_we = q1[0].we;
          m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
        end
      end
    end
  end

  // ---------------- slaves ----------------
  bit rnd_slv = 0;

  initial begin
    prdata = '0; pready = '0; pslverr = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rnd_slv) begin
        pready  = 4'($urandom);
        pslverr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
        for (int i = 0; i < 4; i++) prdata[i*32 +: 32] = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  // One outstanding transfer: owner, latched request, validity and
  // cycles elapsed since the grant edge.
  bit          mb_busy, mb_own, mb_last, mb_valid, mb_we;
  logic [31:0] mb_addr, mb_wdata;
  int          mb_age;
  bit          e_rdy0, e_rdy1, e_err0, e_err1;
  logic [31:0] e_rd0, e_rd1;

  always @(posedge clk or negedge reset) begin
    bit el0, el1, done, derr;
    int idx;
    logic [31:0] drd;
    if (!reset) begin
      mb_busy = 0; mb_own = 0; mb_last = 1; mb_valid = 0;
      mb_we = 0; mb_addr = 0; mb_wdata = 0; mb_age = 0;
      e_rdy0 = 0; e_rdy1 = 0; e_err0 = 0; e_err1 = 0;
      e_rd0 = 0; e_rd1 = 0;
    end else begin
      el0 = m0_req && !e_rdy0;
      el1 = m1_req && !e_rdy1;
      e_rdy0 = 0; e_rdy1 = 0; e_err0 = 0; e_err1 = 0;
      done = 0; derr = 0; drd = 0;
      if (mb_busy) begin
        idx = int'(mb_addr[15:12]);
        if (!mb_valid) begin
          done = 1; derr = 1;
        end else if (mb_age >= 1 && pready[idx]) begin
          done = 1;
          derr = pslverr[idx];
          drd  = mb_we ? 32'h0 : prdata[idx*32 +: 32];
`ifdef APB_TIMEOUT_EN
        end else if (mb_age == TO) begin
          done = 1; derr = 1;
`endif
        end else begin
          mb_age++;
        end
        if (done) begin
          mb_busy = 0;
          if (mb_own) begin e_rdy1 = 1; e_err1 = derr; e_rd1 = drd; end
          else begin e_rdy0 = 1; e_err0 = derr; e_rd0 = drd; end
        end
      end else if (el0 || el1) begin
        mb_own   = (el0 && el1) ? !mb_last : el1;
        mb_last  = mb_own;
        mb_addr  = mb_own ? m1_addr : m0_addr;
        mb_we    = mb_own ? m1_we : m0_we;
        mb_wdata = mb_own ? m1_wdata : m0_wdata;
        mb_valid = (mb_addr[31:16] == 16'h1000) && (mb_addr[15:12] < 4);
        mb_busy  = 1;
        mb_age   = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ep;
    bit epen;
    ep   = (mb_busy && mb_valid) ? 4'(1 << mb_addr[15:12]) : 4'b0;
    epen = mb_busy && mb_valid && (mb_age >= 1);
    chk("psel", psel, ep);
    chk("penable", penable, epen);
    if (ep != 0) begin
      chk("paddr", paddr, mb_addr);
      chk("pwrite", pwrite, mb_we);
      chk("pwdata", pwdata, mb_wdata);
    end
    chk("m0_ready", m0_ready, e_rdy0);
    chk("m0_err", m0_err, e_err0);
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_ready", m1_ready, e_rdy1);
    chk("m1_err", m1_err, e_err1);
    chk("m1_rdata", m1_rdata, e_rd1);
  end

  // ---------------- directed + random sequence ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m0_req || m1_req
            || mb_busy) && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_idle: bus still busy after %0d cycles", lim);
    end
    step();
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    int k;
    k = $urandom_range(0, 9);
    t.we = 1'($urandom);
    t.wdata = $urandom;
    if (k < 7)
      t.addr = {16'h1000, 4'($urandom_range(0, 3)), 12'($urandom)};
    else if (k < 9)
      t.addr = {16'h1000, 4'($urandom_range(4, 15)), 12'($urandom)};
    else
      t.addr = {16'h1000 ^ 16'($urandom_range(1, 65535)), 16'($urandom)};
    return t;
  endfunction

  initial begin
    int n0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", psel, 4'b0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    reset = 1;
    step();

    // m0 write to GPO, zero-wait slave
    pready = 4'hF;
    q0.push_back('{1'b1, 32'h1000_0000, 32'h0000_000A});
    step();
    step();
    chk("t1_setup_psel", psel, 4'b0001);
    chk("t1_setup_pen", penable, 0);
    step();
    chk("t1_acc_psel", psel, 4'b0001);
    chk("t1_acc_pen", penable, 1);
    chk("t1_pwdata", pwdata, 32'hA);
    step();
    chk("t1_ready", m0_ready, 1);
    chk("t1_err", m0_err, 0);
    chk("t1_psel_off", psel, 4'b0);
    wait_idle(50);

    // m1 read from UART with 4 wait states
    pready = 4'b0111;
    prdata[3*32 +: 32] = 32'h55;
    q1.push_back('{1'b0, 32'h1000_3004, 32'h0});
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_psel", psel, 4'b1000);
      chk("t2_paddr", paddr, 32'h1000_3004);
    end
    step();
    chk("t2_psel_hold", psel, 4'b1000);
    chk("t2_no_ready", m1_ready, 0);
    pready = 4'hF;
    step();
    chk("t2_ready", m1_ready, 1);
    chk("t2_rdata", m1_rdata, 32'h55);
    wait_idle(50);

    // simultaneous requests alternate
    prdata[1*32 +: 32] = 32'h11;
    prdata[2*32 +: 32] = 32'h22;
    order_q.delete();
    q0.push_back('{1'b0, 32'h1000_2000, 32'h0});
    q0.push_back('{1'b0, 32'h1000_2004, 32'h0});
    q1.push_back('{1'b0, 32'h1000_1000, 32'h0});
    q1.push_back('{1'b0, 32'h1000_1004, 32'h0});
    wait_idle(100);
    chk("t3_count", order_q.size(), 4);
    if (order_q.size() == 4) begin
      chk("t3_g0", order_q[0], 0);
      chk("t3_g1", order_q[1], 1);
      chk("t3_g2", order_q[2], 0);
      chk("t3_g3", order_q[3], 1);
    end
    chk("t3_rd0", m0_rdata, 32'h22);
    chk("t3_rd1", m1_rdata, 32'h11);

    // decode errors
    q0.push_back('{1'b0, 32'h2000_0000, 32'h0});
    step();
    step();
    chk("t4a_psel", psel, 4'b0);
    step();
    chk("t4a_ready", m0_ready, 1);
    chk("t4a_err", m0_err, 1);
    chk("t4a_rdata", m0_rdata, 0);
    wait_idle(50);
    q0.push_back('{1'b0, 32'h1000_F000, 32'h0});
    step();
    step();
    chk("t4b_psel", psel, 4'b0);
    step();
    chk("t4b_ready", m0_ready, 1);
    chk("t4b_err", m0_err, 1);
    wait_idle(50);

    // slave error on GPIO
    pslverr = 4'b0100;
    q0.push_back('{1'b1, 32'h1000_2008, 32'h1234});
    wait_idle(50);
    chk("t5_slverr", last_err0, 1);
    pslverr = 4'b0;

    // reset mid-ACCESS
    pready = 4'b0;
    q0.push_back('{1'b0, 32'h1000_1000, 32'h0});
    step();
    step();
    step();
    chk("t6_in_access", penable, 1);
    reset = 0;
    #1;
    chk("t6_psel", psel, 4'b0);
    chk("t6_pen", penable, 0);
    chk("t6_ready", m0_ready, 0);
    step();
    reset = 1;
    pready = 4'hF;
    n0 = n_done0;
    repeat (10) step();
    chk("t6_no_ready_after", n_done0 - n0, 0);

    // stalled slave: timeout or indefinite wait
    pready = 4'b0;
    q1.push_back('{1'b0, 32'h1000_1000, 32'h0});
    step();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 9; i++) begin
      step();
      chk("t7_wait_ready", m1_ready, 0);
      chk("t7_wait_psel", psel, 4'b0010);
    end
    step();
    chk("t7_tmo_ready", m1_ready, 1);
    chk("t7_tmo_err", m1_err, 1);
    chk("t7_tmo_rdata", m1_rdata, 0);
    chk("t7_tmo_psel", psel, 4'b0);
    wait_idle(50);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t7_no_ready", m1_ready, 0);
    end
    chk("t7_psel_hold", psel, 4'b0010);
    pready = 4'hF;
    wait_idle(50);
`endif

    // randomized traffic
    rnd_slv = 1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (q0.size() < 3 && $urandom_range(0, 3) == 0) q0.push_back(rnd_txn());
      if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(rnd_txn());
    end
    rnd_slv = 0;
    step();
    pready = 4'hF;
    pslverr = 4'b0;
    wait_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
